ring_mem_port: RTL and testbench

// Parametrised ring-side front end for the DDR memory controller, successor to the single-client coherent mux.
// - Terminates the address/write-data ring: nullifies consumed slots and owns the token.
// - Queues memory ops, write lines and coherence resends for the downstream memory FSM.
// - New: N round-robin local read clients, tagged by index; configurable line width, queue depths and DMC window.

---
 rtl/ring_mem_port_pkg.sv | 29 ++
 rtl/ring_mem_port_fifo.sv | 54 +++++
 rtl/ring_mem_port.sv | 193 +++++++++++++++++++
 tb/tb_ring_mem_port.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_mem_port_pkg.sv
// Shared definitions for the ring memory port: slot types, op entry layout, FSM states.
package ring_mem_port_pkg;

  localparam logic [3:0] SLOT_NULL       = 4'h0;
  localparam logic [3:0] SLOT_TOKEN      = 4'h1;
  localparam logic [3:0] SLOT_ADDRESS    = 4'h2;
  localparam logic [3:0] SLOT_WRITEDATA  = 4'h3;
  localparam logic [3:0] SLOT_DMCADDRESS = 4'h4;
  localparam logic [3:0] SLOT_DMCDATA    = 4'h5;

  localparam int unsigned OP_W        = 40;
  localparam int unsigned OP_DEST_LSB = 36;
  localparam int unsigned OP_TYPE_LSB = 32;
  localparam int unsigned ADDR_W      = 26;

  // Memory-op / resend entry: {dest, type, payload}
  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  kind;
    logic [31:0] payload;
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/ring_mem_port_fifo.sv
// First-word-fall-through FIFO with occupancy count; dout reads 0 while empty.
module ring_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/ring_mem_port.sv
// Ring-side front end of the DDR controller: slot termination, token ownership,
// op/write-line/resend queues and round-robin local read clients.
module ring_mem_port
  import ring_mem_port_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned OPQ_DEPTH      = 64,
  parameter int unsigned WDQ_DEPTH      = 1024,
  parameter int unsigned WDQ_MARGIN     = 512,
  parameter int unsigned RSQ_DEPTH      = 64,
  parameter int unsigned N_CLIENTS      = 2,
  parameter int unsigned DMC_WINDOW     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   ring_in,
  input  logic [3:0]                    slot_type_in,
  input  logic [3:0]                    source_in,
  output logic [31:0]                   ring_out,
  output logic [3:0]                    slot_type_out,
  output logic [3:0]                    source_out,
  input  logic                          inhibit,
  input  logic [N_CLIENTS-1:0]          cl_req,
  input  logic [ADDR_W*N_CLIENTS-1:0]   cl_addr,
  output logic [N_CLIENTS-1:0]          cl_ack,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [OP_W-1:0]               op_data,
  output logic                          wd_valid,
  input  logic                          wd_ready,
  output logic [32*WORDS_PER_LINE-1:0]  wd_data,
  input  logic                          rs_valid,
  output logic                          rs_ready,
  input  logic [OP_W-1:0]               rs_data,
  output logic [$clog2(WDQ_DEPTH):0]    wdq_count,
  output logic                          overflow
);

  localparam int unsigned WC_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned RR_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned DMC_W = $clog2(DMC_WINDOW + 1);
  localparam int unsigned OQC_W = $clog2(OPQ_DEPTH) + 1;
  localparam int unsigned WQC_W = $clog2(WDQ_DEPTH) + 1;
  localparam int unsigned RQC_W = $clog2(RSQ_DEPTH) + 1;

  state_t                          state, state_nxt;
  logic [RR_W-1:0]                 rr_ptr, grant_idx;
  logic                            found, grant;
  logic [ADDR_W-1:0]               grant_addr;
  logic                            op_push, dmc_reload;
  op_t                             op_din, rs_head;
  logic [DMC_W-1:0]                dmc_cnt;
  logic [WC_W-1:0]                 wcnt;
  logic [WORDS_PER_LINE-1:0][31:0] line_q;
  logic                            line_push, wr_word;
  logic [OQC_W-1:0]                opq_count;
  logic [RQC_W-1:0]                rsq_count;
  logic                            rs_avail, rs_pop, rs_full, wdq_af;
  logic [31:0]                     ring_nxt;
  logic [3:0]                      slot_nxt, src_nxt;
  logic                            slot_is_addr, slot_is_dmca;

  assign slot_is_addr = (slot_type_in == SLOT_ADDRESS);
  assign slot_is_dmca = (slot_type_in == SLOT_DMCADDRESS);
  assign wdq_af       = (wdq_count >= WQC_W'(WDQ_DEPTH - WDQ_MARGIN));
  assign rs_full      = (rsq_count == RQC_W'(RSQ_DEPTH));
  assign rs_ready     = ~rs_full;
  assign wr_word      = (slot_type_in == SLOT_WRITEDATA) ||
                        ((slot_type_in == SLOT_DMCDATA) && (dmc_cnt != '0));

  // Round-robin pick: lowest requester at or above rr_ptr, then wrap below it
  always_comb begin
    found      = 1'b0;
    grant_idx  = '0;
    grant_addr = '0;
    for (int j = 0; j < int'(N_CLIENTS); j++) begin
      if (!found && cl_req[j] && (RR_W'(j) >= rr_ptr)) begin
        found      = 1'b1;
        grant_idx  = RR_W'(j);
        grant_addr = cl_addr[j*ADDR_W +: ADDR_W];
      end
    end
    for (int j = 0; j < int'(N_CLIENTS); j++) begin
      if (!found && cl_req[j] && (RR_W'(j) < rr_ptr)) begin
        found      = 1'b1;
        grant_idx  = RR_W'(j);
        grant_addr = cl_addr[j*ADDR_W +: ADDR_W];
      end
    end
    grant  = found && !slot_is_addr && !slot_is_dmca &&
             (opq_count <= OQC_W'(OPQ_DEPTH - 2));
    cl_ack = '0;
    if (grant) cl_ack[grant_idx] = 1'b1;
  end

  // Op queue source select: ring Address, modified DMCAddress, then local client
  always_comb begin
    op_push    = 1'b0;
    dmc_reload = 1'b0;
    op_din     = '{dest: 4'h0, kind: SLOT_ADDRESS, payload: 32'h0};
    if (slot_is_addr && !ring_in[31]) begin
      op_push = 1'b1;
      op_din  = '{dest: source_in, kind: slot_type_in, payload: ring_in};
    end else if (slot_is_dmca && (ring_in[31:30] == 2'b11)) begin
      op_push    = 1'b1;
      dmc_reload = 1'b1;
      op_din     = '{dest: source_in, kind: SLOT_ADDRESS, payload: {4'h0, ring_in[27:0]}};
    end else if (grant) begin
      op_push = 1'b1;
      op_din  = '{dest: 4'h0, kind: SLOT_ADDRESS,
                  payload: {2'b00, 4'(grant_idx), grant_addr}};
    end
  end

  // Token FSM and ring output select
  always_comb begin
    state_nxt = state;
    rs_pop    = 1'b0;
    if ((slot_type_in == SLOT_TOKEN) || (source_in == 4'h0) ||
        (slot_is_addr && ring_in[31])) begin
      ring_nxt = 32'h0;
      slot_nxt = SLOT_NULL;
      src_nxt  = 4'h0;
    end else begin
      ring_nxt = ring_in;
      slot_nxt = slot_type_in;
      src_nxt  = source_in;
    end
    case (state)
      ST_IDLE: if (!inhibit && !wdq_af) state_nxt = ST_DUMP;
      ST_DUMP: begin
        if (rs_avail) begin
          rs_pop   = 1'b1;
          ring_nxt = rs_head.payload;
          slot_nxt = rs_head.kind;
          src_nxt  = rs_head.dest;
        end else begin
          ring_nxt  = 32'h0;
          slot_nxt  = SLOT_TOKEN;
          src_nxt   = 4'h0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (slot_type_in == SLOT_TOKEN)
                 state_nxt = (!inhibit && !wdq_af) ? ST_DUMP : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ring_out      <= 32'h0;
      slot_type_out <= SLOT_NULL;
      source_out    <= 4'h0;
      rr_ptr        <= '0;
      dmc_cnt       <= '0;
      wcnt          <= '0;
      line_q        <= '0;
      line_push     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      ring_out      <= ring_nxt;
      slot_type_out <= slot_nxt;
      source_out    <= src_nxt;
      if (grant) rr_ptr <= (grant_idx == RR_W'(N_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
      if (dmc_reload)          dmc_cnt <= DMC_W'(DMC_WINDOW);
      else if (dmc_cnt != '0)  dmc_cnt <= dmc_cnt - 1'b1;
      if (wr_word) begin
        line_q[wcnt] <= ring_in;
        wcnt         <= wcnt + 1'b1;
      end
      line_push <= wr_word && (wcnt == WC_W'(WORDS_PER_LINE - 1));
      overflow  <= overflow ||
                   (op_push && (opq_count == OQC_W'(OPQ_DEPTH))) ||
                   (line_push && (wdq_count == WQC_W'(WDQ_DEPTH)));
    end
  end

  ring_fifo #(.WIDTH(OP_W), .DEPTH(OPQ_DEPTH)) u_opq (
    .clock(clock), .reset(reset), .push(op_push), .din(op_din), .pop(op_ready),
    .dout(op_data), .valid(op_valid), .count(opq_count));

  ring_fifo #(.WIDTH(32*WORDS_PER_LINE), .DEPTH(WDQ_DEPTH)) u_wdq (
    .clock(clock), .reset(reset), .push(line_push), .din(line_q), .pop(wd_ready),
    .dout(wd_data), .valid(wd_valid), .count(wdq_count));

  ring_fifo #(.WIDTH(OP_W), .DEPTH(RSQ_DEPTH)) u_rsq (
    .clock(clock), .reset(reset), .push(rs_valid), .din(rs_data), .pop(rs_pop),
    .dout(rs_head), .valid(rs_avail), .count(rsq_count));

endmodule

// File: tb/tb_ring_mem_port.sv
// Scoreboard bench for ring_mem_port: stimulus queues expectations, negedge monitor checks.
module tb_ring_mem_port;
  import ring_mem_port_pkg::*;

  logic         clock;
  logic         reset;
  logic [31:0]  ring_in;
  logic [3:0]   slot_type_in, source_in;
  logic [31:0]  ring_out;
  logic [3:0]   slot_type_out, source_out;
  logic         inhibit;
  logic [1:0]   cl_req, cl_ack;
  logic [51:0]  cl_addr;
  logic         op_valid, op_ready, wd_valid, wd_ready, rs_valid, rs_ready, overflow;
  logic [39:0]  op_data, rs_data;
  logic [127:0] wd_data;
  logic [10:0]  wdq_count;

  logic [39:0]  op_q[$];
  logic [127:0] wd_q[$];
  logic [39:0]  ring_q[$];
  int           errors = 0;
  int           checks = 0;

  ring_mem_port dut (
    .clock(clock), .reset(reset), .ring_in(ring_in), .slot_type_in(slot_type_in),
    .source_in(source_in), .ring_out(ring_out), .slot_type_out(slot_type_out),
    .source_out(source_out), .inhibit(inhibit), .cl_req(cl_req), .cl_addr(cl_addr),
    .cl_ack(cl_ack), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .rs_valid(rs_valid),
    .rs_ready(rs_ready), .rs_data(rs_data), .wdq_count(wdq_count), .overflow(overflow));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h required nothing", name, act);
  endtask

  task automatic drive(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    @(posedge clock);
    #2;
    slot_type_in = t;
    source_in    = s;
    ring_in      = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(SLOT_NULL, 4'h0, 32'h0);
  endtask

  function automatic logic [39:0] pk(input logic [3:0] a, input logic [3:0] b, input logic [31:0] c);
    return {a, b, c};
  endfunction

  // Monitor: every handshake or non-Null ring slot consumes one expectation
  always @(negedge clock) begin
    if (!reset) begin
      if (op_valid && op_ready) begin
        if (op_q.size() == 0) unexpected("op_unexpected", 128'(op_data));
        else check("op_data", 128'(op_data), 128'(op_q.pop_front()));
      end
      if (wd_valid && wd_ready) begin
        if (wd_q.size() == 0) unexpected("wd_unexpected", wd_data);
        else check("wd_data", wd_data, wd_q.pop_front());
      end
      if (slot_type_out != SLOT_NULL) begin
        if (ring_q.size() == 0) unexpected("ring_unexpected", 128'({slot_type_out, source_out, ring_out}));
        else check("ring_out", 128'({slot_type_out, source_out, ring_out}), 128'(ring_q.pop_front()));
      end
    end
  end

  logic [1:0]   ack_exp [3] = '{2'b01, 2'b10, 2'b01};
  logic [25:0]  caddr   [2] = '{26'h0000AB0, 26'h1234567};
  logic [39:0]  rs_vec  [3] = '{{4'h3, SLOT_WRITEDATA, 32'h000000A1},
                                {4'h4, SLOT_ADDRESS,   32'h000000B2},
                                {4'h5, SLOT_DMCDATA,   32'h000000C3}};
  logic [127:0] line_v;

  initial begin
    reset = 1'b1; ring_in = '0; slot_type_in = SLOT_NULL; source_in = '0;
    inhibit = 1'b0; cl_req = '0; cl_addr = {caddr[1], caddr[0]};
    op_ready = 1'b1; wd_ready = 1'b1; rs_valid = 1'b0; rs_data = '0;
    #1;
    check("reset_wdq_count", 128'(wdq_count), 128'(0));
    check("reset_slot_out", 128'(slot_type_out), 128'(SLOT_NULL));
    repeat (2) @(posedge clock);
    ring_q.push_back(pk(SLOT_TOKEN, 4'h0, 32'h0));
    #2 reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 check("token_cycle2", 128'(slot_type_out), 128'(SLOT_TOKEN));

    // Address bit 31 is nullified and not queued; a normal sourced Address passes and queues
    drive(SLOT_ADDRESS, 4'h0, 32'h8000_0010);
    idle(2);
    check("null_addr_no_op", 128'(op_valid), 128'(0));
    op_q.push_back(pk(4'h6, SLOT_ADDRESS, 32'h0000_1234));
    ring_q.push_back(pk(SLOT_ADDRESS, 4'h6, 32'h0000_1234));
    drive(SLOT_ADDRESS, 4'h6, 32'h0000_1234);
    idle(3);

    // Write line assembly
    wd_ready = 1'b0;
    wd_q.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    for (int i = 1; i <= 4; i++) drive(SLOT_WRITEDATA, 4'h0, 32'(i * 32'h11));
    idle(3);
    check("wdq_count_one", 128'(wdq_count), 128'(1));
    drive(SLOT_NULL, 4'h0, 32'h0);
    wd_ready = 1'b1;
    idle(2);

    // Two held clients alternate starting at index 0
    for (int i = 0; i < 3; i++) begin
      op_q.push_back(pk(4'h0, SLOT_ADDRESS, {2'b00, 4'(i % 2), caddr[i % 2]}));
      drive(SLOT_NULL, 4'h0, 32'h0);
      cl_req = 2'b11;
      #1 check("cl_ack_rr", 128'(cl_ack), 128'(ack_exp[i]));
    end
    drive(SLOT_NULL, 4'h0, 32'h0);
    cl_req = 2'b00;
    idle(3);

    // Address slot beats client 0; client is granted on the next free slot
    op_q.push_back(pk(4'h0, SLOT_ADDRESS, 32'h0000_0777));
    op_q.push_back(pk(4'h0, SLOT_ADDRESS, {2'b00, 4'h0, caddr[0]}));
    drive(SLOT_ADDRESS, 4'h0, 32'h0000_0777);
    cl_req = 2'b01;
    #1 check("cl_ack_deferred", 128'(cl_ack), 128'(0));
    drive(SLOT_NULL, 4'h0, 32'h0);
    #1 check("cl_ack_after", 128'(cl_ack), 128'(2'b01));
    drive(SLOT_NULL, 4'h0, 32'h0);
    cl_req = 2'b00;
    idle(3);

    // DMC window: modified address queues and opens window; late DMCData is ignored
    op_q.push_back(pk(4'h0, SLOT_ADDRESS, 32'h0000_0123));
    wd_q.push_back({32'hD3, 32'hD2, 32'hD1, 32'hD0});
    drive(SLOT_DMCADDRESS, 4'h0, 32'hC000_0123);
    for (int i = 0; i < 4; i++) drive(SLOT_DMCDATA, 4'h0, 32'hD0 + 32'(i));
    idle(6);
    drive(SLOT_DMCDATA, 4'h0, 32'hEE);
    drive(SLOT_DMCADDRESS, 4'h0, 32'h4000_0001);
    drive(SLOT_DMCDATA, 4'h0, 32'hEF);
    wd_q.push_back({32'h54, 32'h53, 32'h52, 32'h51});
    for (int i = 0; i < 4; i++) drive(SLOT_WRITEDATA, 4'h0, 32'h51 + 32'(i));
    idle(4);

    // Resend replay on token arrival, then a fresh Token
    for (int i = 0; i < 3; i++) begin
      drive(SLOT_NULL, 4'h0, 32'h0);
      rs_valid = 1'b1;
      rs_data  = rs_vec[i];
      #1 check("rs_ready", 128'(rs_ready), 128'(1));
    end
    drive(SLOT_NULL, 4'h0, 32'h0);
    rs_valid = 1'b0;
    for (int i = 0; i < 3; i++) ring_q.push_back(pk(rs_vec[i][35:32], rs_vec[i][39:36], rs_vec[i][31:0]));
    ring_q.push_back(pk(SLOT_TOKEN, 4'h0, 32'h0));
    drive(SLOT_TOKEN, 4'h0, 32'h0);
    idle(7);
    check("resend_done", 128'(ring_q.size()), 128'(0));
    ring_q.push_back(pk(SLOT_TOKEN, 4'h0, 32'h0));
    drive(SLOT_TOKEN, 4'h0, 32'h0);
    idle(4);
    check("wait_token_again", 128'(ring_q.size()), 128'(0));

    // Op queue overflow: 65 pushes into 64 entries
    op_ready = 1'b0;
    check("overflow_clear", 128'(overflow), 128'(0));
    for (int i = 0; i < 65; i++) begin
      if (i < 64) op_q.push_back(pk(4'h0, SLOT_ADDRESS, 32'h100 + 32'(i)));
      drive(SLOT_ADDRESS, 4'h0, 32'h100 + 32'(i));
    end
    idle(2);
    check("overflow_set", 128'(overflow), 128'(1));
    op_ready = 1'b1;
    idle(70);

    // Write-line queue at threshold withholds the token until one line drains
    wd_ready = 1'b0;
    for (int ln = 0; ln < 512; ln++) begin
      for (int w = 0; w < 4; w++) begin
        line_v[w*32 +: 32] = {16'(ln), 16'(w)};
        drive(SLOT_WRITEDATA, 4'h0, {16'(ln), 16'(w)});
      end
      wd_q.push_back(line_v);
    end
    idle(3);
    check("wdq_count_512", 128'(wdq_count), 128'(512));
    drive(SLOT_TOKEN, 4'h0, 32'h0);
    idle(8);
    ring_q.push_back(pk(SLOT_TOKEN, 4'h0, 32'h0));
    drive(SLOT_NULL, 4'h0, 32'h0);
    wd_ready = 1'b1;
    drive(SLOT_NULL, 4'h0, 32'h0);
    wd_ready = 1'b0;
    #1 check("wdq_count_511", 128'(wdq_count), 128'(511));
    idle(6);
    check("token_released", 128'(ring_q.size()), 128'(0));
    wd_ready = 1'b1;
    idle(520);
    check("wdq_drained", 128'(wdq_count), 128'(0));

    // Asynchronous reset in the middle of a line
    drive(SLOT_WRITEDATA, 4'h0, 32'h61);
    drive(SLOT_WRITEDATA, 4'h0, 32'h62);
    #1 reset = 1'b1;
    slot_type_in = SLOT_NULL;
    ring_in = 32'h0;
    #1;
    check("rst_wdq_count", 128'(wdq_count), 128'(0));
    check("rst_op_valid", 128'(op_valid), 128'(0));
    check("rst_wd_valid", 128'(wd_valid), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_slot_out", 128'(slot_type_out), 128'(SLOT_NULL));
    ring_q.push_back(pk(SLOT_TOKEN, 4'h0, 32'h0));
    @(posedge clock);
    #2 reset = 1'b0;
    wd_q.push_back({32'h74, 32'h73, 32'h72, 32'h71});
    for (int i = 0; i < 4; i++) drive(SLOT_WRITEDATA, 4'h0, 32'h71 + 32'(i));
    idle(8);

    check("op_q_empty", 128'(op_q.size()), 128'(0));
    check("wd_q_empty", 128'(wd_q.size()), 128'(0));
    check("ring_q_empty", 128'(ring_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
